// File: rtl/mean_scan_controller.sv
// Reads N = 2^LOG2_N consecutive samples from a registered-read memory and emits their round-half-up mean.
// Latency: start on edge 0 -> reads in cycles 1..N, mean_valid in cycle N+2. No backpressure: memory answers every read.
module mean_scan_controller #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int LOG2_N = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cont_mode,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic [DATA_W-1:0] mean_out,
  output logic              mean_valid
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int SUM_W = ACC_W + 1;
  localparam int HALF  = 1 << (LOG2_N - 1);
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [LOG2_N-1:0] cnt;
  logic [ACC_W-1:0]  acc;
  logic [ADDR_W-1:0] base_q;
  logic [SUM_W-1:0]  round_sum;
  logic              enter_scan;
  logic              stay_scan;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // abort outranks every other transition, including start in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = SCAN;
      SCAN:    if (abort) state_nxt = IDLE;
               else if (cnt == CNT_LAST) state_nxt = DRAIN;
      DRAIN:   state_nxt = abort ? IDLE : DONE;
      DONE:    state_nxt = (cont_mode && !abort) ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_scan = (state_nxt == SCAN) && (state != SCAN);
  assign stay_scan  = (state_nxt == SCAN) && (state == SCAN);
  assign busy       = (state != IDLE);
  assign mean_valid = (state == DONE);

  // Final sample is still on mem_rd_data during DRAIN, so it joins the sum here
  assign round_sum = SUM_W'(acc) + SUM_W'(mem_rd_data) + SUM_W'(HALF);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      base_q    <= '0;
      cnt       <= '0;
      acc       <= '0;
      mean_out  <= '0;
    end else begin
      mem_rd_en <= (state_nxt == SCAN);
      if (enter_scan) begin
        cnt <= '0;
        acc <= '0;
        if (state == IDLE) begin
          base_q   <= base_addr;
          mem_addr <= base_addr;
        end else begin
          mem_addr <= base_q;
        end
      end else if (stay_scan) begin
        cnt      <= cnt + LOG2_N'(1);
        mem_addr <= mem_addr + ADDR_W'(1);
      end
      // The first SCAN cycle has no returned data yet
      if (state == SCAN && cnt != '0) acc <= acc + ACC_W'(mem_rd_data);
      if (state == DRAIN && !abort) mean_out <= DATA_W'(round_sum >> LOG2_N);
    end
  end

endmodule
